// File: rtl/uart_frame_rx.sv
// UART byte receiver followed by a framed-packet parser.
// Frame layout: HEAD0 HEAD1 payload[PAYLOAD_LEN] checksum TAIL.
module uart_frame_rx #(
  parameter int          CLK_FREQ    = 50000000,
  parameter int          BAUD        = 115200,
  parameter int          MSB_FIRST   = 1,
  parameter int          PARITY      = 0,
  parameter int          PAYLOAD_LEN = 5,
  parameter logic [7:0]  HEAD0       = 8'hAA,
  parameter logic [7:0]  HEAD1       = 8'h55,
  parameter logic [7:0]  TAIL        = 8'hEF,
  parameter int          TMO_BITS    = 32
) (
  input  logic                       clkin,
  input  logic                       rst_n,
  input  logic                       rxd,
  output logic                       byte_valid,
  output logic [7:0]                 byte_data,
  output logic                       frame_valid,
  output logic [8*PAYLOAD_LEN-1:0]   frame_data,
  output logic                       chk_err,
  output logic                       frm_err
);

  localparam int DIV     = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(DIV + 1);
  localparam int TMO_CYC = TMO_BITS * DIV;
  localparam int TW      = $clog2(TMO_CYC + 1);
  localparam int PW      = $clog2(PAYLOAD_LEN + 1);
  localparam logic [CW-1:0] HALF     = CW'(DIV / 2);
  localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
  // Two less than the period: one cycle for byte_valid to reach the frame FSM, one for the registered pulse.
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 2);
  localparam logic [PW-1:0] PAY_LAST = PW'(PAYLOAD_LEN - 1);

  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PAR, B_STOP} byte_state_t;
  typedef enum logic [2:0] {F_H0, F_H1, F_PAY, F_CHK, F_TL} frame_state_t;

  byte_state_t  bstate;
  frame_state_t fstate;

  logic          sync1, sync2, rx_q;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          par_ok;
  logic          byte_err;

  logic [PW-1:0]            pay_cnt;
  logic [8*PAYLOAD_LEN-1:0] pay_buf;
  logic [7:0]               sum;
  logic                     chk_ok;
  logic [TW-1:0]            tmo;

  always_comb begin
    par_ok = 1'b1;
    if (PARITY == 1)      par_ok = (^shreg) ^ par_bit;
    else if (PARITY == 2) par_ok = ~((^shreg) ^ par_bit);
  end

  // Byte receiver: start is qualified at mid-bit, later bits sampled DIV apart.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      rx_q       <= 1'b1;
      bstate     <= B_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      byte_data  <= '0;
    end else begin
      sync1      <= rxd;
      sync2      <= sync1;
      rx_q       <= sync2;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (bstate)
        B_IDLE: begin
          bit_cnt <= '0;
          if (rx_q && !sync2) bstate <= B_START;
        end
        B_START: begin
          if (bit_cnt == HALF) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            bstate  <= sync2 ? B_IDLE : B_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (bit_cnt == LAST) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (MSB_FIRST != 0) shreg <= {shreg[6:0], sync2};
            else                shreg <= {sync2, shreg[7:1]};
            if (bit_idx == 3'd7) bstate <= (PARITY != 0) ? B_PAR : B_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        B_PAR: begin
          if (bit_cnt == LAST) begin
            bit_cnt <= '0;
            par_bit <= sync2;
            bstate  <= B_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (bit_cnt == LAST) begin
            bit_cnt <= '0;
            bstate  <= B_IDLE;
            if (sync2 && par_ok) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              byte_err <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: bstate <= B_IDLE;
      endcase
    end
  end

  // Frame parser driven by the registered byte strobes.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      fstate      <= F_H0;
      pay_cnt     <= '0;
      pay_buf     <= '0;
      sum         <= '0;
      chk_ok      <= 1'b0;
      tmo         <= '0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      chk_err     <= 1'b0;
      frm_err     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      chk_err     <= 1'b0;
      frm_err     <= 1'b0;
      if (byte_err && (fstate inside {F_PAY, F_CHK, F_TL})) begin
        frm_err <= 1'b1;
        fstate  <= F_H0;
        tmo     <= '0;
      end else if (byte_valid) begin
        tmo <= '0;
        case (fstate)
          F_H0: if (byte_data == HEAD0) fstate <= F_H1;
          F_H1: begin
            if (byte_data == HEAD1) begin
              fstate  <= F_PAY;
              pay_cnt <= '0;
              sum     <= '0;
            end else if (byte_data != HEAD0) begin
              fstate <= F_H0;
            end
          end
          F_PAY: begin
            pay_buf      <= pay_buf << 8;
            pay_buf[7:0] <= byte_data;
            sum          <= sum + byte_data;
            if (pay_cnt == PAY_LAST) fstate <= F_CHK;
            else                     pay_cnt <= pay_cnt + 1'b1;
          end
          F_CHK: begin
            chk_ok <= (byte_data == sum);
            fstate <= F_TL;
          end
          F_TL: begin
            fstate <= F_H0;
            if (byte_data != TAIL) begin
              frm_err <= 1'b1;
            end else if (chk_ok) begin
              frame_valid <= 1'b1;
              frame_data  <= pay_buf;
            end else begin
              chk_err <= 1'b1;
            end
          end
          default: fstate <= F_H0;
        endcase
      end else if (fstate inside {F_PAY, F_CHK, F_TL}) begin
        if (tmo == TMO_LAST) begin
          frm_err <= 1'b1;
          fstate  <= F_H0;
          tmo     <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end else begin
        tmo <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: serial frames driven bit by bit, outcomes checked against an expected-event queue.
// BAUD is raised so that DIV is 20 and the whole run stays short.
module tb_uart_frame_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 2_500_000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int PL       = 5;
  localparam int TMO_BITS = 32;
  localparam int TMO_CYC  = TMO_BITS * DIV;
  localparam int W        = 8 * PL;
  localparam int EW       = W + 2;
  localparam logic [1:0] K_FRAME = 2'd1;
  localparam logic [1:0] K_CHK   = 2'd2;
  localparam logic [1:0] K_FRM   = 2'd3;

  logic         clkin;
  logic         rst_n;
  logic         rxd;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         frame_valid;
  logic [W-1:0] frame_data;
  logic         chk_err;
  logic         frm_err;

  uart_frame_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MSB_FIRST(1), .PARITY(0), .PAYLOAD_LEN(PL),
    .HEAD0(8'hAA), .HEAD1(8'h55), .TAIL(8'hEF), .TMO_BITS(TMO_BITS)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .rxd(rxd),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_valid(frame_valid), .frame_data(frame_data),
    .chk_err(chk_err), .frm_err(frm_err)
  );

  // clock / reset
  initial clkin = 1'b0;
  always #10 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  initial begin
    #4_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]    exp_byte_q[$];
  logic [W-1:0]  last_frame = '0;
  int bv_cyc  = 0;
  int err_cyc = 0;
  logic [1:0]    mon_kind;
  logic [EW-1:0] mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [W-1:0] data);
    exp_q.push_back({kind, data});
  endtask

  always @(negedge clkin) begin
    if (rst_n) begin
      if (byte_valid) begin
        bv_cyc = cyc;
        check("byte_pending", 64'(exp_byte_q.size() > 0), 64'(1));
        if (exp_byte_q.size() > 0) check("byte_data", 64'(byte_data), 64'(exp_byte_q.pop_front()));
      end
      if (frame_valid || chk_err || frm_err) begin
        check("exclusive", 64'(2'(frame_valid) + 2'(chk_err) + 2'(frm_err)), 64'(1));
        mon_kind = frame_valid ? K_FRAME : (chk_err ? K_CHK : K_FRM);
        if (frm_err) err_cyc = cyc;
        check("ev_pending", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("ev_kind", 64'(mon_kind), 64'(mon_e[EW-1:W]));
          if (mon_kind == K_FRAME) begin
            check("frame_data", 64'(frame_data), 64'(mon_e[W-1:0]));
            last_frame = mon_e[W-1:0];
          end else begin
            check("frame_hold", 64'(frame_data), 64'(last_frame));
          end
        end
      end
    end
  end

  // driver tasks
  task automatic send_bit(input logic b);
    rxd = b;
    repeat (DIV) @(negedge clkin);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    if (good_stop) exp_byte_q.push_back(b);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(good_stop);
    send_bit(1'b1);
  endtask

  task automatic send_seq(input logic [127:0] seq, input int n);
    for (int i = 0; i < n; i++) send_byte(seq[8*(n-1-i) +: 8], 1'b1);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || exp_byte_q.size() != 0) && k < budget) begin
      @(negedge clkin);
      k++;
    end
    check("drain_events", 64'(exp_q.size()), 64'(0));
    check("drain_bytes", 64'(exp_byte_q.size()), 64'(0));
    exp_q.delete();
    exp_byte_q.delete();
    repeat (2 * DIV) @(negedge clkin);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_valid"},  64'(byte_valid),  64'(0));
    check({tag, "_byte_data"},   64'(byte_data),   64'(0));
    check({tag, "_frame_valid"}, 64'(frame_valid), 64'(0));
    check({tag, "_frame_data"},  64'(frame_data),  64'(0));
    check({tag, "_chk_err"},     64'(chk_err),     64'(0));
    check({tag, "_frm_err"},     64'(frm_err),     64'(0));
  endtask

  initial begin
    rxd   = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clkin);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (4 * DIV) @(negedge clkin);

    // good frame, then a long idle in H0 during which nothing may fire
    push_ev(K_FRAME, 40'h0502000000);
    send_seq({8'hAA, 8'h55, 8'h05, 8'h02, 8'h00, 8'h00, 8'h00, 8'h07, 8'hEF}, 9);
    drain(20 * DIV);
    repeat (TMO_CYC + 100) @(negedge clkin);

    // leading junk and a repeated HEAD0
    push_ev(K_FRAME, 40'h0102030405);
    send_seq({8'h01, 8'h02, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0F, 8'hEF}, 12);
    drain(20 * DIV);

    // bad checksum: chk_err, frame_data must hold
    push_ev(K_CHK, '0);
    send_seq({8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01, 8'hEF}, 9);
    drain(20 * DIV);
    check("chk_hold", 64'(frame_data), 64'(40'h0102030405));

    // 3rd payload byte with a low stop bit, then a good frame
    push_ev(K_FRM, '0);
    push_ev(K_FRAME, 40'h0502000000);
    send_seq({8'hAA, 8'h55, 8'h05, 8'h02}, 4);
    send_byte(8'h00, 1'b0);
    send_seq({8'h00, 8'h00, 8'h07, 8'hEF}, 4);
    send_seq({8'hAA, 8'h55, 8'h05, 8'h02, 8'h00, 8'h00, 8'h00, 8'h07, 8'hEF}, 9);
    drain(20 * DIV);

    // inter-byte timeout, then a good frame proves the parser is back in H0
    push_ev(K_FRM, '0);
    err_cyc = 0;
    send_seq({8'hAA, 8'h55, 8'h01}, 3);
    drain(TMO_CYC + 20 * DIV);
    check("tmo_latency", 64'(err_cyc - bv_cyc), 64'(TMO_CYC));
    push_ev(K_FRAME, 40'h0502000000);
    send_seq({8'hAA, 8'h55, 8'h05, 8'h02, 8'h00, 8'h00, 8'h00, 8'h07, 8'hEF}, 9);
    drain(20 * DIV);

    // reset mid-frame: everything cleared, no timeout afterwards, next frame accepted
    send_seq({8'hAA, 8'h55, 8'h02}, 3);
    drain(20 * DIV);
    rst_n = 1'b0;
    @(negedge clkin);
    rst_n = 1'b1;
    check_all_zero("midreset");
    last_frame = '0;
    repeat (TMO_CYC + 100) @(negedge clkin);
    push_ev(K_FRAME, 40'h0102030405);
    send_seq({8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0F, 8'hEF}, 9);
    drain(20 * DIV);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning the clkin frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1, meaning data bits arrive MSB first (1) or LSB first (0).
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 The block SHALL have parameter PAYLOAD_LEN, default 5, meaning payload bytes per frame (1..16).
REQ-006 The block SHALL have parameters HEAD0, default 8'hAA, HEAD1, default 8'h55, and TAIL, default 8'hEF, meaning the frame delimiters.
REQ-007 The block SHALL have parameter TMO_BITS, default 32, meaning the inter-byte timeout in bit periods.
REQ-008 The block SHALL have port clkin, input, 1 bit, the single clock.
REQ-009 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-010 The block SHALL have port rxd, input, 1 bit, the asynchronous serial line, idle high.
REQ-011 The block SHALL have port byte_valid, output, 1 bit, a one-cycle pulse per received byte.
REQ-012 The block SHALL have port byte_data, output, 8 bits, the last received byte.
REQ-013 The block SHALL have port frame_valid, output, 1 bit, a one-cycle pulse per accepted frame.
REQ-014 The block SHALL have port frame_data, output, 8*PAYLOAD_LEN bits, the payload with the first payload byte in the MSBs.
REQ-015 The block SHALL have port chk_err, output, 1 bit, a one-cycle pulse on checksum mismatch.
REQ-016 The block SHALL have port frm_err, output, 1 bit, a one-cycle pulse on a framing, parity, tail or timeout error.

Function
REQ-017 rxd SHALL pass through a 2-flop synchroniser before any use.
REQ-018 DIV SHALL equal CLK_FREQ/BAUD using integer division (434 at the defaults); a bit counter SHALL count 0..DIV-1.
REQ-019 The byte FSM SHALL have the states IDLE, START, DATA, PAR and STOP.
- IDLE->START: synchronised rxd falls.
- START: at DIV/2, rxd low -> DATA; rxd high -> IDLE, a glitch with no error.
- DATA: samples 8 bits, each DIV after the previous one.
- PAR: entered only when PARITY!=0.
- STOP: samples one bit.
REQ-020 Bits SHALL be assembled MSB-first when MSB_FIRST=1 and LSB-first otherwise.
REQ-021 A stop bit sampled low, or a parity mismatch, SHALL raise an internal byte error instead of byte_valid.
- This happens in the cycle after the stop sample.
- The byte FSM then returns to IDLE immediately and resynchronises on the next falling edge.
REQ-022 Otherwise, byte_valid SHALL pulse in the cycle after the stop-bit sample, with byte_data held until the next byte.
REQ-023 The frame FSM SHALL have the states H0, H1, PAY, CHK and TL, and SHALL advance on byte_valid.
- H0: HEAD0 -> H1; any other byte stays in H0.
- H1: HEAD1 -> PAY; HEAD0 stays in H1; any other byte -> H0.
- PAY: stores PAYLOAD_LEN bytes, then -> CHK.
- CHK: latches the compare of the received byte against the 8-bit sum modulo 256 of the payload, then -> TL.
- TL: always -> H0.
REQ-024 In TL, the outcome SHALL be decided as follows, with each pulse one cycle after the tail byte's byte_valid.
- Byte==TAIL and checksum good: frame_valid pulses and frame_data is loaded in the same cycle.
- Byte==TAIL and checksum bad: chk_err pulses.
- Byte!=TAIL: frm_err pulses.
REQ-025 frame_data SHALL change only together with frame_valid; a rejected frame SHALL leave it unchanged.
REQ-026 A byte error in H0 or H1 SHALL be ignored; in PAY, CHK or TL it SHALL pulse frm_err and force H0.
REQ-027 In the states PAY, CHK and TL, if no byte_valid occurs within TMO_BITS*DIV cycles of the previous one, the block SHALL pulse frm_err and go to H0.
REQ-028 The timeout counter SHALL be cleared on every byte_valid and SHALL be idle in H0 and H1.
REQ-029 frame_valid, chk_err and frm_err SHALL be mutually exclusive in any cycle.

Reset
REQ-030 While rst_n is low at a clkin edge, the block SHALL reset the following.
- Both FSMs go to IDLE and H0.
- All counters, the checksum accumulator and the synchroniser are cleared, with the synchroniser reset to 1.
- byte_valid, frame_valid, chk_err and frm_err are 0.
- byte_data and frame_data are 0.
REQ-031 A reset mid-byte or mid-frame SHALL discard the partial data and produce no pulse.

Verification (defaults, 20 ns clock, 8681 ns bits)
REQ-032 Bytes AA 55 05 02 00 00 00 07 EF -> frame_valid pulses exactly once, with frame_data=40'h0502000000 and no error pulses.
REQ-033 Bytes 01 02 AA AA 55 01 02 03 04 05 0F EF -> the junk bytes and extra AA are ignored, and one frame_valid pulses with frame_data=40'h0102030405.
REQ-034 Bytes AA 55 01 02 03 04 05 01 EF -> chk_err pulses once, there is no frame_valid, and frame_data keeps its previous value.
REQ-035 A valid frame with its 3rd payload byte sent with a low stop bit -> frm_err pulses once, and the next good frame AA 55 05 02 00 00 00 07 EF is accepted.
REQ-036 Sending AA 55 01 followed by line idle -> frm_err pulses 32*434 cycles after that byte's byte_valid, and the FSM is back in H0.
REQ-037 rst_n pulsed low for 1 cycle after AA 55 02 -> all outputs are 0, no pulse occurs, and a following good frame is accepted.
